stepper_multi_controller: RTL



---
 rtl/stepper_pkg.sv | 24 ++
 rtl/stepper_channel.sv | 161 ++++++++++++++++
 rtl/stepper_multi_controller.sv | 50 +++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types and helpers for the multi-axis step/direction generator.
// STEPPER_SYNC_START_EN (optional) enables the ARMED state used for synchronised starts.
package stepper_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SETUP,
    ST_HIGH,
    ST_LOW
  } state_e;

  // Operates on sign-extended values so channels up to 64 bits wide share it.
  function automatic logic [63:0] abs_steps(input logic signed [63:0] v);
    return v[63] ? -v : v;
  endfunction

  function automatic logic [63:0] clamp_min(input logic [63:0] v, input logic [63:0] lo);
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/stepper_channel.sv
// One axis: command latch, direction setup, fixed-width step pulses at a clamped period.
// STEPPER_SYNC_START_EN adds sync_go and the ARMED hold state.
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned PULSE_WIDTH = 1000,
  parameter int unsigned DIR_SETUP   = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef STEPPER_SYNC_START_EN
  input  logic                    sync_go,
`endif
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [CNT_W-1:0] cmd_steps,
  input  logic        [CNT_W-1:0] cmd_period,
  input  logic                    abort,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    busy,
  output logic                    done
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic               abort_pend_q, abort_pend_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    per_d        = per_q;
    abort_pend_d = abort_pend_q;
    dir_d        = dir_q;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort blocks acceptance; a zero-step command completes without moving
        if (cmd_valid && ready_q && !abort) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d        = CNT_W'(abs_steps(64'(cmd_steps)));
            per_d        = CNT_W'(clamp_min(64'(cmd_period), 64'(PULSE_WIDTH) + 64'd1));
            dir_d        = ~cmd_steps[CNT_W-1];
            abort_pend_d = 1'b0;
            cnt_d        = CNT_W'(DIR_SETUP - 1);
`ifdef STEPPER_SYNC_START_EN
            state_d      = ST_ARMED;
`else
            state_d      = ST_SETUP;
`endif
          end
        end
      end
`ifdef STEPPER_SYNC_START_EN
      ST_ARMED: begin
        if (abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (sync_go) begin
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(DIR_SETUP - 1);
        end
      end
`endif
      ST_SETUP: begin
        if (abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_W'(PULSE_WIDTH - 1);
          rem_d   = rem_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HIGH: begin
        // a pulse in flight always runs to full width before abort takes effect
        if (abort) abort_pend_d = 1'b1;
        if (cnt_q == '0) begin
          if (abort_pend_q || abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOW;
            cnt_d   = per_q - CNT_W'(PULSE_WIDTH + 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          if (rem_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_HIGH;
            cnt_d   = CNT_W'(PULSE_WIDTH - 1);
            rem_d   = rem_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    step_d  = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      per_q        <= '0;
      abort_pend_q <= 1'b0;
      step_q       <= 1'b0;
      dir_q        <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      per_q        <= per_d;
      abort_pend_q <= abort_pend_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
    end
  end

  assign step_out  = step_q;
  assign dir_out   = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule

// File: rtl/stepper_multi_controller.sv
// N-axis step/direction pulse generator: independent stepper_channel per axis on flattened buses.
// STEPPER_SYNC_START_EN adds the sync_go input for coordinated starts of armed axes.
module stepper_multi_controller
  import stepper_pkg::*;
#(
  parameter int          NUM_AXES    = 2,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned PULSE_WIDTH = 1000,
  parameter int unsigned DIR_SETUP   = 50
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef STEPPER_SYNC_START_EN
  input  logic                      sync_go,
`endif
  input  logic [NUM_AXES-1:0]       cmd_valid,
  output logic [NUM_AXES-1:0]       cmd_ready,
  input  logic [NUM_AXES*CNT_W-1:0] cmd_steps,
  input  logic [NUM_AXES*CNT_W-1:0] cmd_period,
  input  logic [NUM_AXES-1:0]       abort,
  output logic [NUM_AXES-1:0]       step_out,
  output logic [NUM_AXES-1:0]       dir_out,
  output logic [NUM_AXES-1:0]       busy,
  output logic [NUM_AXES-1:0]       done
);

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    stepper_channel #(
      .CNT_W      (CNT_W),
      .PULSE_WIDTH(PULSE_WIDTH),
      .DIR_SETUP  (DIR_SETUP)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef STEPPER_SYNC_START_EN
      .sync_go   (sync_go),
`endif
      .cmd_valid (cmd_valid[i]),
      .cmd_ready (cmd_ready[i]),
      .cmd_steps (cmd_steps[i*CNT_W +: CNT_W]),
      .cmd_period(cmd_period[i*CNT_W +: CNT_W]),
      .abort     (abort[i]),
      .step_out  (step_out[i]),
      .dir_out   (dir_out[i]),
      .busy      (busy[i]),
      .done      (done[i])
    );
  end

endmodule
